// File: rtl/regfile_sb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_sb_if
// Brief    : Read/write/issue bundle between the pipeline and regfile_sb.
// Revision : 1.0
// ============================================================================
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] ra3;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] rd3;
    logic              busy1;
    logic              busy2;
    logic              busy3;
    logic [DATA_W-1:0] r15;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic              we4;
    logic [ADDR_W-1:0] wa4;
    logic [DATA_W-1:0] wd4;
    logic              iss_v;
    logic [ADDR_W-1:0] iss_a;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output ra1, ra2, ra3, r15,
        output we3, wa3, wd3, we4, wa4, wd4,
        output iss_v, iss_a,
        input  rd1, rd2, rd3, busy1, busy2, busy3, pend_cnt
    );

    modport slave (
        input  ra1, ra2, ra3, r15,
        input  we3, wa3, wd3, we4, wa4, wd4,
        input  iss_v, iss_a,
        output rd1, rd2, rd3, busy1, busy2, busy3, pend_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : 3R/2W register file with optional bypass and a busy scoreboard
//            for long-latency writebacks; PC index reads the external r15.
// Revision : 1.0
// ============================================================================
module regfile_sb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int PC_IDX     = 15,
    parameter int BYPASS     = 1,
    parameter int RESET_ZERO = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    localparam int                c_NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_PC   = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] w_rf [c_NREG];
    logic [c_NREG-1:0] r_busy;
    logic [c_NREG-1:0] w_busy_nxt;
    logic [ADDR_W:0]   r_pend;
    logic [ADDR_W:0]   w_pend_nxt;

    // The PC slot has no storage and can never be marked busy.
    for (genvar r = 0; r < c_NREG; r++) begin : g_reg
        if (r == PC_IDX) begin : g_pc
            assign w_rf[r]       = '0;
            assign w_busy_nxt[r] = 1'b0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;
            logic              w_hit3;
            logic              w_hit4;
            logic              w_hit_iss;

            assign w_hit3    = bus.we3   && (bus.wa3   == ADDR_W'(r));
            assign w_hit4    = bus.we4   && (bus.wa4   == ADDR_W'(r));
            assign w_hit_iss = bus.iss_v && (bus.iss_a == ADDR_W'(r));

            always_ff @(posedge clk) begin
                if (reset) begin
                    if (RESET_ZERO != 0) begin
                        r_q <= '0;
                    end
                end else if (w_hit4) begin
                    r_q <= bus.wd4;
                end else if (w_hit3) begin
                    r_q <= bus.wd3;
                end
            end

            assign w_rf[r]       = r_q;
            assign w_busy_nxt[r] = w_hit_iss ? 1'b1 : (w_hit4 ? 1'b0 : r_busy[r]);
        end
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < c_NREG; i++) begin
            w_pend_nxt = w_pend_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            r_pend <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    logic [ADDR_W-1:0] w_ra    [3];
    logic [DATA_W-1:0] w_rd    [3];
    logic [2:0]        w_rbusy;

    assign w_ra[0] = bus.ra1;
    assign w_ra[1] = bus.ra2;
    assign w_ra[2] = bus.ra3;

    for (genvar p = 0; p < 3; p++) begin : g_rd
        logic [DATA_W-1:0] w_val;

        // Port 4 has priority, matching which write lands in storage.
        always_comb begin
            w_val = w_rf[w_ra[p]];
            if (BYPASS != 0) begin
                if (bus.we4 && (bus.wa4 == w_ra[p])) begin
                    w_val = bus.wd4;
                end else if (bus.we3 && (bus.wa3 == w_ra[p])) begin
                    w_val = bus.wd3;
                end
            end
        end

        assign w_rd[p]    = (w_ra[p] == c_PC) ? bus.r15 : w_val;
        assign w_rbusy[p] = (w_ra[p] == c_PC) ? 1'b0 : r_busy[w_ra[p]];
    end

    assign bus.rd1      = w_rd[0];
    assign bus.rd2      = w_rd[1];
    assign bus.rd3      = w_rd[2];
    assign bus.busy1    = w_rbusy[0];
    assign bus.busy2    = w_rbusy[1];
    assign bus.busy3    = w_rbusy[2];
    assign bus.pend_cnt = r_pend;

endmodule
`default_nettype wire
